// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: one resource shared by NREQ level-sensitive requesters.
// Optional hold-time limit with revoke and re-request masking is enabled by defining RR_TIMEOUT_EN.
module rr_grant_scheduler #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW      = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            busy,
  output logic            timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [NREQ-1:0] ptr;
  logic [NREQ-1:0] eligible;
  logic [IW:0]     pick;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic            held;
  logic [NREQ-1:0] ptr_next;

  // Returns {valid, index} of the first eligible bit at or above the pointer, wrapping to bit 0.
  function automatic logic [IW:0] pick_first(input logic [NREQ-1:0] p,
                                             input logic [NREQ-1:0] e);
    int          base;
    int          j;
    logic [IW:0] r;
    base = 0;
    r    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (p[i]) base = i;
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = base + k;
      if (j >= NREQ) j = j - NREQ;
      if (e[j]) r = {1'b1, IW'(j)};
    end
    return r;
  endfunction

`ifdef RR_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0]   hold_cnt;
  logic [NREQ-1:0] mask;

  assign eligible = req & ~mask;
`else
  assign eligible = req;
  assign timeout  = 1'b0;
`endif

  assign pick     = pick_first(ptr, eligible);
  assign pick_vld = pick[IW];
  assign pick_idx = pick[IW-1:0];
  assign held     = |(req & grant);
  assign ptr_next = {grant[NREQ-2:0], grant[NREQ-1]};

  // NOTE: every register here is sequential state, so it is assigned only with
  // non-blocking (<=) and every one of them gets a value in the reset branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
      ptr       <= NREQ'(1);
`ifdef RR_TIMEOUT_EN
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      mask      <= '0;
`endif
    end else begin
`ifdef RR_TIMEOUT_EN
      timeout <= 1'b0;
      // A revoked requester is unmasked once its request has been seen low.
      mask    <= mask & req;
`endif
      case (state)
        IDLE: begin
          if (en && pick_vld) begin
            grant     <= NREQ'(1) << pick_idx;
            grant_idx <= pick_idx;
            busy      <= 1'b1;
            state     <= BUSY;
`ifdef RR_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        BUSY: begin
          if (!held) begin
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            ptr       <= ptr_next;
            state     <= IDLE;
          end
`ifdef RR_TIMEOUT_EN
          else if (hold_cnt == CW'(MAX_HOLD - 1)) begin
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            ptr       <= ptr_next;
            state     <= IDLE;
            timeout   <= 1'b1;
            mask      <= (mask & req) | grant;
          end else begin
            hold_cnt  <= hold_cnt + CW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an index-based behavioural model.
module tb_rr_grant_scheduler;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 8;
  localparam int IW       = $clog2(NREQ);

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            en    = 1'b1;
  logic [NREQ-1:0] req   = '0;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            busy;
  logic            timeout;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  rr_grant_scheduler #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Behavioural model: the owner is an integer index (-1 when idle), the pointer an index.
  int              m_owner = -1;
  int              m_ptr   = 0;
  int              m_held  = 0;
  bit [NREQ-1:0]   m_block = '0;
  bit              m_to    = 1'b0;

  always @(posedge clk or negedge reset) begin
    int j;
    if (!reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_block = '0;
      m_to    = 1'b0;
    end else begin
      m_to    = 1'b0;
      m_block = m_block & req;
      if (m_owner < 0) begin
        if (en) begin
          for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (m_owner < 0 && req[j] && !m_block[j]) begin
              m_owner = j;
              m_held  = 1;
            end
          end
        end
      end else if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
`ifdef RR_TIMEOUT_EN
      else if (m_held == MAX_HOLD) begin
        m_block[m_owner] = 1'b1;
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_to    = 1'b1;
      end
`endif
      else begin
        m_held++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("m_idx", 32'(grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check("m_busy", 32'(busy), 32'(m_owner >= 0));
      check("m_timeout", 32'(timeout), 32'(m_to));
    end
  end

  initial begin
    logic [NREQ-1:0] seq [4];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;

    // Reset held with all requests high.
    req = 4'b1111;
    en  = 1'b1;
    #1 reset = 1'b0;
    chk_on = 1'b1;
    repeat (2) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();

    // Full rotation, each grantee holding 3 cycles.
    for (int k = 0; k < 4; k++) begin
      for (int h = 0; h < 3; h++) begin
        if (h > 0) tick();
        check("rot_grant", 32'(grant), 32'(seq[k]));
      end
      req[k] = 1'b0;
      tick();
      check("rot_idle", 32'(grant), 32'd0);
      if (k < 3) begin
        req = 4'b1111;
        tick();
      end else begin
        req = '0;
      end
    end

    // Pointer at bit 2 after serving requester 1; scan wraps to bit 0.
    req = 4'b0010; tick();
    check("wrap_pre", 32'(grant), 32'b0010);
    req = '0; tick();
    req = 4'b0011; tick();
    check("wrap_grant", 32'(grant), 32'b0001);
    req = '0; tick();
    check("wrap_idle", 32'(grant), 32'd0);

    // Enable gating of new grants; en has no effect on a held grant.
    en = 1'b0; req = 4'b0100;
    repeat (5) begin
      tick();
      check("en_block", 32'(grant), 32'd0);
    end
    en = 1'b1; tick();
    check("en_grant", 32'(grant), 32'b0100);
    check("en_idx", 32'(grant_idx), 32'd2);
    en = 1'b0;
    repeat (3) begin
      tick();
      check("en_hold", 32'(grant), 32'b0100);
    end
    req = '0; en = 1'b1; tick();

    // Asynchronous reset mid-grant, then restart from bit 0.
    req = 4'b0010; tick();
    check("ar_pre", 32'(grant), 32'b0010);
    #2 reset = 1'b0;
    #1;
    check("ar_grant", 32'(grant), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_idx", 32'(grant_idx), 32'd0);
    @(negedge clk);
    reset = 1'b1; req = 4'b1010;
    tick();
    check("ar_restart", 32'(grant), 32'b0010);
    req = '0; tick();

    // Grantee drops request in the very cycle its grant appears.
    req = 4'b0100; tick();
    check("one_grant", 32'(grant), 32'b0100);
    check("one_busy", 32'(busy), 32'd1);
    req = '0; tick();
    check("one_after", 32'(grant), 32'd0);
    check("one_busy0", 32'(busy), 32'd0);
    check("one_to", 32'(timeout), 32'd0);

`ifdef RR_TIMEOUT_EN
    // Stuck request 0 revoked after MAX_HOLD cycles, then masked until seen low.
    reset = 1'b0; tick();
    reset = 1'b1; req = 4'b1001; tick();
    for (int i = 0; i < MAX_HOLD; i++) begin
      if (i > 0) tick();
      check("to_hold", 32'(grant), 32'b0001);
    end
    tick();
    check("to_grant0", 32'(grant), 32'd0);
    check("to_pulse", 32'(timeout), 32'd1);
    tick();
    check("to_next", 32'(grant), 32'b1000);
    check("to_pulse0", 32'(timeout), 32'd0);
    req = 4'b0001; tick();
    check("to_rel", 32'(grant), 32'd0);
    tick();
    check("to_masked", 32'(grant), 32'd0);
    req = '0; tick();
    req = 4'b0001; tick();
    check("to_unmask", 32'(grant), 32'b0001);
    req = '0; tick();
`endif

    // Randomized traffic with slowly changing requests, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      en = ($urandom_range(0, 9) != 0);
      tick();
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
